// File: rtl/audio_dac_pkg.sv
// Shared types, constants and helpers for the delta-sigma audio DAC back-end.
// Holds the quarter-wave sine table used by the built-in test tone generator.
package audio_dac_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int INTEG_W       = 20;
    localparam int OSR_BASE      = 32;
    localparam int SINE_LUT_BITS = 6;

    typedef logic signed [INTEG_W-1:0] integ_t;
    typedef logic signed [INTEG_W+1:0] wide_t;

    localparam integ_t FB_POS    = integ_t'(32768);
    localparam integ_t FB_NEG    = -FB_POS;
    localparam integ_t INTEG_MAX = integ_t'({1'b0, {(INTEG_W-1){1'b1}}});
    localparam integ_t INTEG_MIN = integ_t'({1'b1, {(INTEG_W-1){1'b0}}});

    // round(32767 * sin(2*pi*k/256)) for k = 0..63
    localparam logic [14:0] SINE_LUT [2**SINE_LUT_BITS] = '{
        15'd0,     15'd804,   15'd1608,  15'd2411,  15'd3212,  15'd4011,  15'd4808,  15'd5602,
        15'd6392,  15'd7179,  15'd7962,  15'd8739,  15'd9512,  15'd10278, 15'd11039, 15'd11793,
        15'd12539, 15'd13278, 15'd14009, 15'd14732, 15'd15447, 15'd16151, 15'd16846, 15'd17530,
        15'd18204, 15'd18867, 15'd19519, 15'd20159, 15'd20787, 15'd21402, 15'd22005, 15'd22594,
        15'd23170, 15'd23731, 15'd24279, 15'd24811, 15'd25329, 15'd25832, 15'd26319, 15'd26790,
        15'd27245, 15'd27683, 15'd28105, 15'd28510, 15'd28898, 15'd29268, 15'd29621, 15'd29956,
        15'd30273, 15'd30571, 15'd30852, 15'd31113, 15'd31356, 15'd31580, 15'd31785, 15'd31971,
        15'd32137, 15'd32285, 15'd32412, 15'd32521, 15'd32609, 15'd32678, 15'd32728, 15'd32757
    };

    function automatic logic [7:0] osr_last(input logic [1:0] osr);
        return 8'((OSR_BASE << osr) - 1);
    endfunction

    function automatic integ_t sat_integ(input wide_t v);
        if (v > wide_t'(INTEG_MAX)) begin
            return INTEG_MAX;
        end else if (v < wide_t'(INTEG_MIN)) begin
            return INTEG_MIN;
        end
        return integ_t'(v);
    endfunction

endpackage

// File: rtl/audio_dac_sinegen.sv
// Test tone source: 8-bit phase accumulator advanced on each sample tick,
// presents the sine of the phase it will step to so the top can latch it on the tick.
module audio_dac_sinegen
    import audio_dac_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_en,
    input  logic [4:0] i_step,
    output sample_t    o_sample_next
);

    logic [7:0]  r_phase;
    logic [7:0]  w_phase_next;
    logic [1:0]  w_quad;
    logic [5:0]  w_idx;
    logic [5:0]  w_idx_mirror;
    logic [14:0] w_mag;
    sample_t     w_pos;

    assign w_phase_next = r_phase + {3'b000, i_step};
    assign w_quad       = w_phase_next[7:6];
    assign w_idx        = w_phase_next[5:0];
    assign w_idx_mirror = 6'd0 - w_idx;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (i_tick && i_en) begin
            r_phase <= w_phase_next;
        end
    end

    // Odd quadrants read the table backwards; index 0 there is the peak, which the table lacks
    always_comb begin
        w_mag = SINE_LUT[w_idx];
        if (w_quad[0]) begin
            w_mag = (w_idx == 6'd0) ? 15'h7FFF : SINE_LUT[w_idx_mirror];
        end
    end

    assign w_pos         = sample_t'({1'b0, w_mag});
    assign o_sample_next = w_quad[1] ? -w_pos : w_pos;

endmodule

// File: rtl/audio_dac.sv
// Audio DAC back-end: 16-sample write FIFO, sample-rate tick, volume shift and a
// 1st/2nd-order delta-sigma modulator producing a complementary 1-bit stream.
module audio_dac
    import audio_dac_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] fifo_i,
    input  logic        fifo_rdy_i,
    output logic        fifo_ack_o,
    output logic        fifo_full_o,
    output logic        fifo_empty_o,
    input  logic        mode_i,
    input  logic [3:0]  volume_i,
    input  logic [1:0]  osr_i,
    output logic        ds_o,
    output logic        ds_n_o,
    input  logic        tst_fifo_loop_i,
    input  logic        tst_sinegen_en_i,
    input  logic [4:0]  tst_sinegen_step_i
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    // ---------------- sample tick ----------------
    logic [7:0] r_tick_cnt;
    logic [1:0] r_osr;
    logic       w_tick;

    assign w_tick = (r_tick_cnt == osr_last(r_osr));

    // A new oversampling ratio is only picked up as the counter wraps
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tick_cnt <= '0;
            r_osr      <= osr_i;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_osr      <= osr_i;
        end else begin
            r_tick_cnt <= r_tick_cnt + 8'd1;
        end
    end

    // ---------------- write FIFO ----------------
    sample_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_loop_ofs;
    logic [CW-1:0]   r_count;
    logic            r_ack;
    logic            r_empty;
    logic            r_full;
    logic            w_wr;
    logic            w_pop;
    logic            w_consume;
    logic [AW-1:0]   w_rd_addr;
    logic [AW-1:0]   w_loop_ofs_next;
    logic [CW-1:0]   w_count_next;

    // Host handshake (4-phase): host raises fifo_rdy_i with fifo_i valid; the sample is
    // written on the first edge with ack low and space free, ack then stays high until
    // the host drops fifo_rdy_i, and a new request is only taken once ack is low again.
    assign w_wr      = fifo_rdy_i && !r_ack && !r_full;
    assign w_pop     = w_tick && !tst_sinegen_en_i && !r_empty;
    assign w_consume = w_pop && !tst_fifo_loop_i;
    assign w_rd_addr = r_rd_ptr + r_loop_ofs;

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_consume) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_wr && w_consume) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Replay position walks the stored samples relative to the head and wraps at count
    always_comb begin
        w_loop_ofs_next = r_loop_ofs;
        if (!tst_fifo_loop_i) begin
            w_loop_ofs_next = '0;
        end else if (w_pop) begin
            if (({1'b0, r_loop_ofs} + CW'(1)) >= r_count) begin
                w_loop_ofs_next = '0;
            end else begin
                w_loop_ofs_next = r_loop_ofs + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= fifo_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_loop_ofs <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_consume) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_loop_ofs <= w_loop_ofs_next;
            r_count    <= w_count_next;
            r_empty    <= (w_count_next == '0);
            r_full     <= (w_count_next == CW'(DEPTH));
            if (w_wr) begin
                r_ack <= 1'b1;
            end else if (!fifo_rdy_i) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign fifo_ack_o   = r_ack;
    assign fifo_empty_o = r_empty;
    assign fifo_full_o  = r_full;

    // ---------------- sample source ----------------
    sample_t w_sine_next;
    sample_t r_held;
    sample_t w_x;

    audio_dac_sinegen u_sinegen (
        .i_clk         (clk_i),
        .i_rst_n       (rst_n_i),
        .i_tick        (w_tick),
        .i_en          (tst_sinegen_en_i),
        .i_step        (tst_sinegen_step_i),
        .o_sample_next (w_sine_next)
    );

    // An empty FIFO on a tick keeps the last sample rather than dropping to zero
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_held <= '0;
        end else if (w_tick && tst_sinegen_en_i) begin
            r_held <= w_sine_next;
        end else if (w_pop) begin
            r_held <= r_mem[w_rd_addr];
        end
    end

    assign w_x = r_held >>> volume_i;

    // ---------------- delta-sigma modulator ----------------
    integ_t r_i1;
    integ_t r_i2;
    logic   r_ds;
    logic   r_mode_d;
    integ_t w_fb;
    wide_t  w_sum1;
    wide_t  w_sum2;
    integ_t w_i1_next;
    integ_t w_i2_next;
    logic   w_mode_chg;

    assign w_fb       = r_ds ? FB_POS : FB_NEG;
    assign w_sum1     = wide_t'(r_i1) + wide_t'(w_x) - wide_t'(w_fb);
    assign w_i1_next  = sat_integ(w_sum1);
    assign w_sum2     = wide_t'(r_i2) + wide_t'(w_i1_next) - wide_t'(w_fb);
    assign w_i2_next  = sat_integ(w_sum2);
    assign w_mode_chg = (mode_i != r_mode_d);

    // The second integrator restarts from zero whenever the loop order is switched
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_i1     <= '0;
            r_i2     <= '0;
            r_ds     <= 1'b0;
            r_mode_d <= mode_i;
        end else begin
            r_i1     <= w_i1_next;
            r_mode_d <= mode_i;
            if (w_mode_chg || !mode_i) begin
                r_i2 <= '0;
            end else begin
                r_i2 <= w_i2_next;
            end
            r_ds <= mode_i ? !w_i2_next[INTEG_W-1] : !w_i1_next[INTEG_W-1];
        end
    end

    assign ds_o   = r_ds;
    assign ds_n_o = ~r_ds;

endmodule

// File: tb/tb_audio_dac.sv
// Directed bench for audio_dac: reset values, FIFO handshake and flags, bitstream
// density for DC inputs in both loop orders, underflow hold, replay and sine source.
module tb_audio_dac;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] fifo_i = '0;
    logic        fifo_rdy_i = 1'b0;
    logic        fifo_ack_o;
    logic        fifo_full_o;
    logic        fifo_empty_o;
    logic        mode_i = 1'b0;
    logic [3:0]  volume_i = '0;
    logic [1:0]  osr_i = '0;
    logic        ds_o;
    logic        ds_n_o;
    logic        tst_fifo_loop_i = 1'b0;
    logic        tst_sinegen_en_i = 1'b0;
    logic [4:0]  tst_sinegen_step_i = '0;

    audio_dac dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .fifo_i             (fifo_i),
        .fifo_rdy_i         (fifo_rdy_i),
        .fifo_ack_o         (fifo_ack_o),
        .fifo_full_o        (fifo_full_o),
        .fifo_empty_o       (fifo_empty_o),
        .mode_i             (mode_i),
        .volume_i           (volume_i),
        .osr_i              (osr_i),
        .ds_o               (ds_o),
        .ds_n_o             (ds_n_o),
        .tst_fifo_loop_i    (tst_fifo_loop_i),
        .tst_sinegen_en_i   (tst_sinegen_en_i),
        .tst_sinegen_step_i (tst_sinegen_step_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= rst_n_i ? cyc + 1 : 0;

    task automatic do_reset(input logic [1:0] osr);
        osr_i   = osr;
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic write_sample(input logic [15:0] d, input int max_wait, output int ok);
        fifo_i     = d;
        fifo_rdy_i = 1'b1;
        ok = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk_i);
            if (fifo_ack_o) begin
                ok = 1;
                break;
            end
        end
        fifo_rdy_i = 1'b0;
        if (ok == 1) begin
            ok = 0;
            for (int i = 0; i < max_wait; i++) begin
                @(negedge clk_i);
                if (!fifo_ack_o) begin
                    ok = 1;
                    break;
                end
            end
        end
    endtask

    task automatic wait_empty(input int max_wait, output int ok);
        ok = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk_i);
            if (fifo_empty_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic measure(input int n, output int ones, output int nbad);
        ones = 0;
        nbad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            if (ds_o) ones++;
            if (ds_n_o !== ~ds_o) nbad++;
        end
    endtask

    // ---------------- DC density vectors ----------------
    // Expected ones in 1024 clocks = (x + 32768) / 64, x = sample >>> vol
    typedef struct {
        logic [15:0] sample;
        logic [3:0]  vol;
        logic        mode;
        int          exp_ones;
        int          tol;
        int          settle;
    } dc_vec_t;

    dc_vec_t vecs [10];

    int ok;
    int ones;
    int nbad;
    int ack_cyc;

    initial begin
        vecs[0] = '{16'h4000, 4'd0,  1'b0, 768,  10, 256};
        vecs[1] = '{16'h4000, 4'd1,  1'b0, 640,  10, 256};
        vecs[2] = '{16'h8000, 4'd15, 1'b0, 512,  10, 256};
        vecs[3] = '{16'hC000, 4'd0,  1'b0, 256,  10, 256};
        vecs[4] = '{16'h2000, 4'd0,  1'b1, 640,  10, 256};
        vecs[5] = '{16'hE000, 4'd1,  1'b1, 448,  10, 256};
        vecs[6] = '{16'h1000, 4'd2,  1'b1, 528,  10, 256};
        vecs[7] = '{16'h7FFF, 4'd0,  1'b0, 1024, 10, 256};
        vecs[8] = '{16'h8000, 4'd0,  1'b0, 0,    10, 256};
        vecs[9] = '{16'h8000, 4'd0,  1'b1, 0,    10, 512};

        // 1. reset values while reset is held
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_ds",    int'(ds_o),         0);
        check_eq("rst_ds_n",  int'(ds_n_o),       1);
        check_eq("rst_empty", int'(fifo_empty_o), 1);
        check_eq("rst_full",  int'(fifo_full_o),  0);
        check_eq("rst_ack",   int'(fifo_ack_o),   0);

        // 2. fill to full at osr=3, 17th request waits for the first pop at edge 256
        do_reset(2'd3);
        for (int i = 0; i < 16; i++) begin
            write_sample(16'(i * 16'h0111), 20, ok);
            check_eq($sformatf("hs_write%0d", i), ok, 1);
            if (i == 14) check_eq("hs_full_at_15", int'(fifo_full_o), 0);
        end
        check_eq("hs_full_at_16",  int'(fifo_full_o),  1);
        check_eq("hs_empty_at_16", int'(fifo_empty_o), 0);
        fifo_i     = 16'h1234;
        fifo_rdy_i = 1'b1;
        ack_cyc    = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (fifo_ack_o) begin
                ack_cyc = cyc;
                break;
            end
        end
        check_eq("hs_ack_after_pop", ack_cyc, 257);
        fifo_rdy_i = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (!fifo_ack_o) begin
                ok = 1;
                break;
            end
        end
        check_eq("hs_ack_release", ok, 1);
        check_eq("hs_full_again", int'(fifo_full_o), 1);

        // reset in the middle of operation drops FIFO contents
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check_eq("midrst_empty", int'(fifo_empty_o), 1);
        check_eq("midrst_full",  int'(fifo_full_o),  0);
        check_eq("midrst_ack",   int'(fifo_ack_o),   0);
        check_eq("midrst_ds",    int'(ds_o),         0);
        check_eq("midrst_ds_n",  int'(ds_n_o),       1);

        // 3/4. DC density table at osr=0
        do_reset(2'd0);
        for (int k = 0; k < 10; k++) begin
            volume_i = vecs[k].vol;
            mode_i   = vecs[k].mode;
            write_sample(vecs[k].sample, 20, ok);
            check_eq($sformatf("dc%0d_write", k), ok, 1);
            wait_empty(100, ok);
            check_eq($sformatf("dc%0d_popped", k), ok, 1);
            repeat (vecs[k].settle) @(negedge clk_i);
            measure(1024, ones, nbad);
            check_rng($sformatf("dc%0d_density", k), ones,
                      vecs[k].exp_ones - vecs[k].tol, vecs[k].exp_ones + vecs[k].tol);
            check_eq($sformatf("dc%0d_ds_n", k), nbad, 0);
        end

        // 5. underflow keeps the last sample
        mode_i   = 1'b0;
        volume_i = 4'd0;
        do_reset(2'd0);
        write_sample(16'h2000, 20, ok);
        check_eq("uf_write", ok, 1);
        wait_empty(100, ok);
        check_eq("uf_empty", ok, 1);
        repeat (64) @(negedge clk_i);
        measure(1024, ones, nbad);
        check_rng("uf_density_a", ones, 630, 650);
        repeat (1000) @(negedge clk_i);
        measure(1024, ones, nbad);
        check_rng("uf_density_b", ones, 630, 650);
        check_eq("uf_still_empty", int'(fifo_empty_o), 1);

        // replay: two extreme samples alternate, FIFO never drains
        tst_fifo_loop_i = 1'b1;
        do_reset(2'd0);
        write_sample(16'h7FFF, 20, ok);
        check_eq("loop_write0", ok, 1);
        write_sample(16'h8000, 20, ok);
        check_eq("loop_write1", ok, 1);
        repeat (512) @(negedge clk_i);
        check_eq("loop_not_empty", int'(fifo_empty_o), 0);
        measure(1024, ones, nbad);
        check_rng("loop_density", ones, 496, 528);
        tst_fifo_loop_i = 1'b0;

        // 6. sine source, step 2, osr 1: positive half then negative half of a 8192-clock period
        tst_sinegen_en_i   = 1'b1;
        tst_sinegen_step_i = 5'd2;
        mode_i             = 1'b1;
        volume_i           = 4'd2;
        do_reset(2'd1);
        for (int i = 0; i < 3; i++) begin
            write_sample(16'h0100, 20, ok);
            check_eq($sformatf("sine_write%0d", i), ok, 1);
        end
        for (int i = 0; i < 100 && cyc < 64; i++) @(negedge clk_i);
        measure(4032, ones, nbad);
        check_rng("sine_pos_half", ones, 2242, 2442);
        check_eq("sine_ds_n", nbad, 0);
        for (int i = 0; i < 200 && cyc < 4160; i++) @(negedge clk_i);
        measure(4032, ones, nbad);
        check_rng("sine_neg_half", ones, 1590, 1790);
        check_eq("sine_fifo_kept", int'(fifo_empty_o), 0);
        check_eq("sine_fifo_not_full", int'(fifo_full_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
